// File: rtl/alu_n_bit_pipe_if.sv
// ----------------------------------------------------------------------------
// alu_n_bit_pipe_if
// Handshake and data bundle between the instruction decode stage, the
// pipelined ALU and the register write-back stage.
//
// Parameters:
//   WIDTH  operand/result width
//   OPC_W  opcode width
//
// Signals:
//   IN_VALID / IN_READY    input handshake (transfer when both high)
//   OP_A, OP_B, OPCODE     operands and operation select
//   OUT_VALID / OUT_READY  output handshake (transfer when both high)
//   ALU_OUT                result
//   CARRY ZERO NEG OVF ERR status flags travelling with ALU_OUT
//
// Modports:
//   master  producer of operations and consumer of results (datapath side)
//   slave   the ALU itself
// ----------------------------------------------------------------------------
interface alu_n_bit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OPC_W = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OP_A;
    logic [WIDTH-1:0] OP_B;
    logic [OPC_W-1:0] OPCODE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] ALU_OUT;
    logic             CARRY;
    logic             ZERO;
    logic             NEG;
    logic             OVF;
    logic             ERR;

    modport master (
        output IN_VALID, OP_A, OP_B, OPCODE, OUT_READY,
        input  IN_READY, OUT_VALID, ALU_OUT, CARRY, ZERO, NEG, OVF, ERR
    );

    modport slave (
        input  IN_VALID, OP_A, OP_B, OPCODE, OUT_READY,
        output IN_READY, OUT_VALID, ALU_OUT, CARRY, ZERO, NEG, OVF, ERR
    );
endinterface

// File: rtl/alu_n_bit_pipe.sv
// ----------------------------------------------------------------------------
// alu_n_bit_pipe
// Two-stage pipelined WIDTH-bit ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands and opcode; stage 2 captures the result and the
// CARRY/ZERO/NEG/OVF/ERR flags. One operation per cycle when not stalled.
//
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    alu_n_bit_pipe_if.slave (handshakes, operands, result, flags)
//
// Build option:
//   ALU_SAT_EN  when defined, opcodes 0xC/0xD are signed saturating add/sub;
//               otherwise they are illegal and no saturation logic exists.
// ----------------------------------------------------------------------------
module alu_n_bit_pipe #(
    parameter int WIDTH = 8,
    parameter int OPC_W = 8
) (
    input  logic CLK,
    input  logic RESET,
    alu_n_bit_pipe_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] WIDTH_V = (SHW + 1)'(WIDTH);
`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH - 1){1'b0}}};
`else
    // Saturation clamp values only exist in the saturating build.
`endif

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
        logic err;
    } flags_t;

    // Signed overflow of a+b: operands agree in sign, result does not.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) & (r_msb != a_msb);
    endfunction

    // Signed overflow of a-b: operands differ in sign, result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) & (r_msb != a_msb);
    endfunction

    logic             s1_v_q,   s1_v_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;
    logic [OPC_W-1:0] s1_op_q,  s1_op_d;
    logic             s2_v_q,   s2_v_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    flags_t           s2_flg_q, s2_flg_d;

    logic                    s1_adv_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic [SHW-1:0]          amt_s;
    logic [WIDTH:0]          sum_s;
    logic [WIDTH:0]          diff_s;
    logic                    add_ovf_s;
    logic                    sub_ovf_s;
    logic [WIDTH:0]          shl_s;
    logic [WIDTH:0]          shr_s;
    logic signed [WIDTH:0]   asr_s;
    logic [WIDTH-1:0]        rol_s;
    logic [WIDTH-1:0]        ror_s;
    logic                    op_hi_zero_s;
`ifdef ALU_SAT_EN
    logic [WIDTH-1:0]        adds_s;
    logic [WIDTH-1:0]        subs_s;
`else
    // No saturating datapath in the default build.
`endif
    logic [WIDTH-1:0]        res_s;
    logic                    carry_s;
    logic                    ovf_s;
    logic                    err_s;
    logic                    cmp_s;
    logic [WIDTH-1:0]        flag_src_s;
    logic [WIDTH-1:0]        alu_res_s;
    flags_t                  alu_flg_s;

    // Handshake: S1 may move on when S2 is empty or being drained this cycle.
    always_comb begin
        s1_adv_s   = ~s2_v_q | bus.OUT_READY;
        in_ready_s = ~s1_v_q | s1_adv_s;
        accept_s   = bus.IN_VALID & in_ready_s;
    end

    // Stage 1 next state: load on accept, empty when advancing without a new op.
    always_comb begin
        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_op_d = s1_op_q;
        if (in_ready_s) begin
            s1_v_d = bus.IN_VALID;
        end else begin
            s1_v_d = s1_v_q;
        end
        if (accept_s) begin
            s1_a_d  = bus.OP_A;
            s1_b_d  = bus.OP_B;
            s1_op_d = bus.OPCODE;
        end else begin
            s1_a_d  = s1_a_q;
            s1_b_d  = s1_b_q;
            s1_op_d = s1_op_q;
        end
    end

    // Candidate results for every operation, all derived from the S1 operands.
    always_comb begin
        amt_s     = s1_b_q[SHW-1:0];
        sum_s     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        // Top bit of the extended difference is the unsigned borrow.
        diff_s    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        add_ovf_s = add_overflow(s1_a_q[MSB], s1_b_q[MSB], sum_s[MSB]);
        sub_ovf_s = sub_overflow(s1_a_q[MSB], s1_b_q[MSB], diff_s[MSB]);
        // Shifts carry one guard bit so the last bit shifted out lands there;
        // with amount 0 the guard bit stays 0.
        shl_s     = {1'b0, s1_a_q} << amt_s;
        shr_s     = {s1_a_q, 1'b0} >> amt_s;
        asr_s     = $signed({s1_a_q, 1'b0}) >>> amt_s;
        // A shift by WIDTH yields 0, so amount 0 degenerates to A.
        rol_s     = (s1_a_q << amt_s) | (s1_a_q >> (WIDTH_V - {1'b0, amt_s}));
        ror_s     = (s1_a_q >> amt_s) | (s1_a_q << (WIDTH_V - {1'b0, amt_s}));
        op_hi_zero_s = ((s1_op_q >> 3'd4) == {OPC_W{1'b0}});
    end

`ifdef ALU_SAT_EN
    // Saturating add/sub: clamp towards the sign of A when overflow occurs.
    always_comb begin
        adds_s = sum_s[MSB:0];
        subs_s = diff_s[MSB:0];
        if (add_ovf_s) begin
            adds_s = s1_a_q[MSB] ? SAT_MIN : SAT_MAX;
        end else begin
            adds_s = sum_s[MSB:0];
        end
        if (sub_ovf_s) begin
            subs_s = s1_a_q[MSB] ? SAT_MIN : SAT_MAX;
        end else begin
            subs_s = diff_s[MSB:0];
        end
    end
`else
    // Opcodes 0xC/0xD fall into the illegal-opcode branch below.
`endif

    // Operation select: result, carry, overflow and legality.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        cmp_s   = 1'b0;
        if (op_hi_zero_s) begin
            case (s1_op_q[3:0])
                4'h0: begin res_s = sum_s[MSB:0];  carry_s = sum_s[WIDTH];  ovf_s = add_ovf_s; end
                4'h1: begin res_s = diff_s[MSB:0]; carry_s = diff_s[WIDTH]; ovf_s = sub_ovf_s; end
                4'h2: res_s = s1_a_q & s1_b_q;
                4'h3: res_s = s1_a_q | s1_b_q;
                4'h4: res_s = s1_a_q ^ s1_b_q;
                4'h5: res_s = ~s1_a_q;
                4'h6: begin res_s = shl_s[MSB:0];   carry_s = shl_s[WIDTH]; end
                4'h7: begin res_s = shr_s[WIDTH:1]; carry_s = shr_s[0];     end
                4'h8: begin res_s = asr_s[WIDTH:1]; carry_s = asr_s[0];     end
                // Rotate carry is the bit that wrapped around.
                4'h9: begin res_s = rol_s; carry_s = (amt_s != {SHW{1'b0}}) & rol_s[0];   end
                4'hA: begin res_s = ror_s; carry_s = (amt_s != {SHW{1'b0}}) & ror_s[MSB]; end
                4'hB: begin cmp_s = 1'b1; carry_s = diff_s[WIDTH]; ovf_s = sub_ovf_s; end
`ifdef ALU_SAT_EN
                4'hC: begin res_s = adds_s; ovf_s = add_ovf_s; end
                4'hD: begin res_s = subs_s; ovf_s = sub_ovf_s; end
`else
                // 0xC/0xD handled by default as illegal.
`endif
                default: err_s = 1'b1;
            endcase
        end else begin
            err_s = 1'b1;
        end
    end

    // Final result and flags; CMP takes ZERO/NEG from A-B, ERR clears everything else.
    always_comb begin
        flag_src_s = cmp_s ? diff_s[MSB:0] : res_s;
        alu_res_s  = {WIDTH{1'b0}};
        alu_flg_s  = '{carry: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0, err: 1'b0};
        if (err_s) begin
            alu_res_s     = {WIDTH{1'b0}};
            alu_flg_s.err = 1'b1;
        end else begin
            alu_res_s       = res_s;
            alu_flg_s.carry = carry_s;
            alu_flg_s.zero  = (flag_src_s == {WIDTH{1'b0}});
            alu_flg_s.neg   = flag_src_s[MSB];
            alu_flg_s.ovf   = ovf_s;
            alu_flg_s.err   = 1'b0;
        end
    end

    // Stage 2 next state: load from S1 on advance, hold while stalled.
    always_comb begin
        s2_v_d   = s2_v_q;
        s2_res_d = s2_res_q;
        s2_flg_d = s2_flg_q;
        if (s1_adv_s) begin
            s2_v_d = s1_v_q;
        end else begin
            s2_v_d = s2_v_q;
        end
        if (s1_adv_s & s1_v_q) begin
            s2_res_d = alu_res_s;
            s2_flg_d = alu_flg_s;
        end else begin
            s2_res_d = s2_res_q;
            s2_flg_d = s2_flg_q;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= {WIDTH{1'b0}};
            s1_b_q  <= {WIDTH{1'b0}};
            s1_op_q <= {OPC_W{1'b0}};
        end else begin
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_op_q <= s1_op_d;
        end
    end

    // Stage 2 registers; these drive the outputs directly.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s2_v_q   <= 1'b0;
            s2_res_q <= {WIDTH{1'b0}};
            s2_flg_q <= '{carry: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0, err: 1'b0};
        end else begin
            s2_v_q   <= s2_v_d;
            s2_res_q <= s2_res_d;
            s2_flg_q <= s2_flg_d;
        end
    end

    assign bus.IN_READY  = in_ready_s;
    assign bus.OUT_VALID = s2_v_q;
    assign bus.ALU_OUT   = s2_res_q;
    assign bus.CARRY     = s2_flg_q.carry;
    assign bus.ZERO      = s2_flg_q.zero;
    assign bus.NEG       = s2_flg_q.neg;
    assign bus.OVF       = s2_flg_q.ovf;
    assign bus.ERR       = s2_flg_q.err;
endmodule

// File: tb/tb_alu_n_bit_pipe.sv
module tb_alu_n_bit_pipe;
    typedef struct packed {
        logic [15:0] res;
        logic c;
        logic z;
        logic n;
        logic o;
        logic e;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_n_bit_pipe_if #(.WIDTH(8),  .OPC_W(8)) bus8();
    alu_n_bit_pipe_if #(.WIDTH(16), .OPC_W(8)) bus16();

    alu_n_bit_pipe #(.WIDTH(8),  .OPC_W(8)) dut8  (.CLK(clk), .RESET(rst_n), .bus(bus8.slave));
    alu_n_bit_pipe #(.WIDTH(16), .OPC_W(8)) dut16 (.CLK(clk), .RESET(rst_n), .bus(bus16.slave));

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    res_t act_q[$];
    int   inflight = 0;
    int   stall_viol = 0;
    int   rdy_viol = 0;
    int   rdy_low_seen = 0;
    bit   prev_stall = 1'b0;
    res_t prev_out;

    function automatic int wrap(int x, int w);
        int m = 1 << w;
        return ((x % m) + m) % m;
    endfunction

    function automatic int sgn(int x, int w);
        return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    endfunction

    // Reference ALU working on plain integers.
    function automatic res_t model(int w, int a, int b, int op);
        res_t r;
        int h = 1 << (w - 1);
        int sa = sgn(a, w);
        int sb = sgn(b, w);
        int amt = b % w;
        int v = 0;
        int c = 0;
        int o = 0;
        int e = 0;
        int t = 0;
        int src;
        bit cmp = 1'b0;
        case (op)
            0: begin v = wrap(a + b, w); c = (a + b) >> w; o = (sa + sb >= h || sa + sb < -h); end
            1: begin v = wrap(a - b, w); c = (a < b); o = (sa - sb >= h || sa - sb < -h); end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = wrap(~a, w);
            6: begin v = wrap(a << amt, w); c = (amt != 0) ? ((a >> (w - amt)) & 1) : 0; end
            7: begin v = a >> amt; c = (amt != 0) ? ((a >> (amt - 1)) & 1) : 0; end
            8: begin v = wrap(sa >>> amt, w); c = (amt != 0) ? ((a >> (amt - 1)) & 1) : 0; end
            9: begin
                t = a;
                for (int i = 0; i < amt; i++) begin c = (t >> (w - 1)) & 1; t = wrap(t * 2 + c, w); end
                v = t;
            end
            10: begin
                t = a;
                for (int i = 0; i < amt; i++) begin c = t & 1; t = (t >> 1) + c * h; end
                v = t;
            end
            11: begin cmp = 1'b1; v = 0; c = (a < b); o = (sa - sb >= h || sa - sb < -h); end
`ifdef ALU_SAT_EN
            12: begin
                t = sa + sb;
                if (t >= h) begin v = h - 1; o = 1; end
                else if (t < -h) begin v = h; o = 1; end
                else v = wrap(t, w);
            end
            13: begin
                t = sa - sb;
                if (t >= h) begin v = h - 1; o = 1; end
                else if (t < -h) begin v = h; o = 1; end
                else v = wrap(t, w);
            end
`endif
            default: e = 1;
        endcase
        src = cmp ? wrap(a - b, w) : v;
        if (e != 0) begin
            r = {16'h0000, 5'b00001};
        end else begin
            r.res = v[15:0];
            r.c   = c[0];
            r.z   = (src == 0);
            r.n   = src[w - 1];
            r.o   = o[0];
            r.e   = 1'b0;
        end
        return r;
    endfunction

    function automatic res_t get8();
        res_t r;
        r.res = {8'h00, bus8.ALU_OUT};
        r.c = bus8.CARRY;
        r.z = bus8.ZERO;
        r.n = bus8.NEG;
        r.o = bus8.OVF;
        r.e = bus8.ERR;
        return r;
    endfunction

    function automatic res_t get16();
        res_t r;
        r.res = bus16.ALU_OUT;
        r.c = bus16.CARRY;
        r.z = bus16.ZERO;
        r.n = bus16.NEG;
        r.o = bus16.OVF;
        r.e = bus16.ERR;
        return r;
    endfunction

    // One clock of the 8-bit pipe: drive after the edge, observe at the falling edge.
    task automatic cycle8(input bit iv, input int a, input int b, input int op, input bit ordy, output bit acc);
        res_t cur;
        bit   exp_rdy;
        @(posedge clk);
        #1;
        bus8.IN_VALID  = iv;
        bus8.OP_A      = a[7:0];
        bus8.OP_B      = b[7:0];
        bus8.OPCODE    = op[7:0];
        bus8.OUT_READY = ordy;
        @(negedge clk);
        cur = get8();
        // Both stages full exactly when two items are held.
        exp_rdy = !(inflight == 2 && !ordy);
        if (bus8.IN_READY !== exp_rdy) rdy_viol++;
        if (bus8.IN_READY === 1'b0) rdy_low_seen++;
        if (prev_stall && (bus8.OUT_VALID !== 1'b1 || cur !== prev_out)) stall_viol++;
        if (bus8.OUT_VALID === 1'b1 && ordy) begin
            act_q.push_back(cur);
            inflight--;
        end
        acc = iv && (bus8.IN_READY === 1'b1);
        if (acc) begin
            exp_q.push_back(model(8, a & 255, b & 255, op & 255));
            inflight++;
        end
        prev_stall = (bus8.OUT_VALID === 1'b1) && !ordy;
        prev_out   = cur;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        act_q.delete();
        stall_viol = 0;
        rdy_viol = 0;
        rdy_low_seen = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus8.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus8.OUT_VALID); end
        checks++;
        if (get8() !== 21'd0) begin errors++; $display("FAIL reset_out_flags: got %h expected 0", get8()); end
        checks++;
        if (get16() !== 21'd0) begin errors++; $display("FAIL reset_out_flags16: got %h expected 0", get16()); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus8.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus8.IN_READY); end
    endtask

    task automatic test_latency();
        bit acc;
        res_t got;
        res_t exp;
        clear_sb();
        cycle8(1'b1, 8'h12, 8'h34, 0, 1'b1, acc);
        cycle8(1'b0, 0, 0, 0, 1'b1, acc);
        checks++;
        if (bus8.OUT_VALID !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", bus8.OUT_VALID); end
        cycle8(1'b0, 0, 0, 0, 1'b1, acc);
        checks++;
        if (bus8.OUT_VALID !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", bus8.OUT_VALID); end
        checks++;
        if (act_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL latency_count: got %0d expected 1", act_q.size());
        end else begin
            got = act_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL latency_data: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_directed();
        string       nm[15] = '{"add_ff_01", "add_7f_01", "sub_10_20", "cmp_33_33", "shl_81_01",
                                "ror_01_09", "asr_80_3", "shr_amt0", "rol_81_01", "cmp_10_20",
                                "sub_80_01", "ill_1f", "ill_0e", "adds_7f_01", "subs_80_01"};
        int          t_op[15] = '{0, 0, 1, 11, 6, 10, 8, 7, 9, 11, 1, 'h1F, 'h0E, 12, 13};
        int          t_a[15]  = '{'hFF, 'h7F, 'h10, 'h33, 'h81, 'h01, 'h80, 'h5A, 'h81, 'h10, 'h80, 'h12, 'h05, 'h7F, 'h80};
        int          t_b[15]  = '{'h01, 'h01, 'h20, 'h33, 'h01, 'h09, 'h03, 'h08, 'h01, 'h20, 'h01, 'h34, 'h03, 'h01, 'h01};
        logic [20:0] t_exp[15];
        bit          acc;
        int          k;
        res_t        got;
        t_exp[0]  = {16'h0000, 5'b11000};
        t_exp[1]  = {16'h0080, 5'b00110};
        t_exp[2]  = {16'h00F0, 5'b10100};
        t_exp[3]  = {16'h0000, 5'b01000};
        t_exp[4]  = {16'h0002, 5'b10000};
        t_exp[5]  = {16'h0080, 5'b10100};
        t_exp[6]  = {16'h00F0, 5'b00100};
        t_exp[7]  = {16'h005A, 5'b00000};
        t_exp[8]  = {16'h0003, 5'b10000};
        t_exp[9]  = {16'h0000, 5'b10100};
        t_exp[10] = {16'h007F, 5'b00010};
        t_exp[11] = {16'h0000, 5'b00001};
        t_exp[12] = {16'h0000, 5'b00001};
`ifdef ALU_SAT_EN
        t_exp[13] = {16'h007F, 5'b00010};
        t_exp[14] = {16'h0080, 5'b00110};
`else
        t_exp[13] = {16'h0000, 5'b00001};
        t_exp[14] = {16'h0000, 5'b00001};
`endif
        for (int i = 0; i < 15; i++) begin
            clear_sb();
            cycle8(1'b1, t_a[i], t_b[i], t_op[i], 1'b1, acc);
            k = 0;
            while (act_q.size() == 0 && k < 6) begin
                cycle8(1'b0, 0, 0, 0, 1'b1, acc);
                k++;
            end
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL %s: got no result expected %h", nm[i], t_exp[i]);
            end else begin
                got = act_q.pop_front();
                if (got !== t_exp[i]) begin errors++; $display("FAIL %s: got %h expected %h", nm[i], got, t_exp[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit   acc;
        int   sent = 0;
        int   a;
        int   b;
        int   op;
        res_t g;
        res_t e;
        clear_sb();
        a = $urandom_range(0, 255); b = $urandom_range(0, 255); op = $urandom_range(0, 11);
        for (int cyc = 0; cyc < 60; cyc++) begin
            cycle8(sent < 8, a, b, op, pat[cyc % 4], acc);
            if (acc) begin
                sent++;
                a = $urandom_range(0, 255); b = $urandom_range(0, 255); op = $urandom_range(0, 11);
            end
        end
        checks++;
        if (act_q.size() != 8 || exp_q.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d/%0d expected 8", act_q.size(), exp_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            g = act_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL bp_data: got %h expected %h", g, e); end
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d violations expected 0", stall_viol); end
        checks++;
        if (rdy_viol != 0) begin errors++; $display("FAIL bp_in_ready: got %0d violations expected 0", rdy_viol); end
        checks++;
        if (rdy_low_seen == 0) begin errors++; $display("FAIL bp_full_seen: got 0 expected >0"); end
    endtask

    task automatic test_random();
        bit   acc;
        int   x;
        int   op;
        int   k = 0;
        res_t g;
        res_t e;
        clear_sb();
        for (int cyc = 0; cyc < 400; cyc++) begin
            x = $urandom_range(0, 17);
            op = (x >= 16) ? (($urandom_range(1, 15) << 4) | $urandom_range(0, 15)) : x;
            cycle8($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255), op,
                   $urandom_range(0, 9) < 7, acc);
        end
        while (inflight > 0 && k < 10) begin
            cycle8(1'b0, 0, 0, 0, 1'b1, acc);
            k++;
        end
        checks++;
        if (act_q.size() != exp_q.size() || exp_q.size() == 0) begin
            errors++; $display("FAIL rnd_count: got %0d expected %0d", act_q.size(), exp_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            g = act_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rnd_data: got %h expected %h", g, e); end
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL rnd_stall_stable: got %0d violations expected 0", stall_viol); end
        checks++;
        if (rdy_viol != 0) begin errors++; $display("FAIL rnd_in_ready: got %0d violations expected 0", rdy_viol); end
    endtask

    task automatic test_reset_midstream();
        bit acc;
        clear_sb();
        cycle8(1'b1, 8'h11, 8'h22, 0, 1'b0, acc);
        cycle8(1'b1, 8'h40, 8'h05, 1, 1'b0, acc);
        cycle8(1'b0, 0, 0, 0, 1'b0, acc);
        checks++;
        if (bus8.OUT_VALID !== 1'b1 || bus8.ALU_OUT !== 8'h33) begin
            errors++; $display("FAIL mid_pre: got %b/%h expected 1/33", bus8.OUT_VALID, bus8.ALU_OUT);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus8.OUT_VALID); end
        checks++;
        if (get8() !== 21'd0) begin errors++; $display("FAIL mid_rst_out: got %h expected 0", get8()); end
        clear_sb();
        inflight = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle8(1'b0, 0, 0, 0, 1'b1, acc);
        checks++;
        if (act_q.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d results expected 0", act_q.size()); end
        checks++;
        if (bus8.IN_READY !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus8.IN_READY); end
    endtask

    task automatic test_wide();
        string       nm[3]  = '{"w16_adds", "w16_ill_1f", "w16_add_wrap"};
        int          t_op[3] = '{12, 'h1F, 0};
        int          t_a[3]  = '{'h7FF0, 'h1234, 'hFFFF};
        int          t_b[3]  = '{'h0100, 'h0001, 'h0001};
        logic [20:0] t_exp[3];
        bit          seen;
        res_t        got;
`ifdef ALU_SAT_EN
        t_exp[0] = {16'h7FFF, 5'b00010};
`else
        t_exp[0] = {16'h0000, 5'b00001};
`endif
        t_exp[1] = {16'h0000, 5'b00001};
        t_exp[2] = {16'h0000, 5'b11000};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus16.IN_VALID = 1'b1;
            bus16.OP_A     = t_a[i][15:0];
            bus16.OP_B     = t_b[i][15:0];
            bus16.OPCODE   = t_op[i][7:0];
            @(posedge clk);
            #1;
            bus16.IN_VALID = 1'b0;
            seen = 1'b0;
            got  = 21'd0;
            for (int k = 0; k < 5 && !seen; k++) begin
                @(negedge clk);
                if (bus16.OUT_VALID === 1'b1) begin seen = 1'b1; got = get16(); end
            end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL %s: got no result expected %h", nm[i], t_exp[i]);
            end else if (got !== t_exp[i]) begin
                errors++; $display("FAIL %s: got %h expected %h", nm[i], got, t_exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus8.IN_VALID   = 1'b0;
        bus8.OP_A       = 8'h00;
        bus8.OP_B       = 8'h00;
        bus8.OPCODE     = 8'h00;
        bus8.OUT_READY  = 1'b1;
        bus16.IN_VALID  = 1'b0;
        bus16.OP_A      = 16'h0000;
        bus16.OP_B      = 16'h0000;
        bus16.OPCODE    = 8'h00;
        bus16.OUT_READY = 1'b1;
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
